rf_mt_banked: RTL and testbench
===============================

Name: rf_mt_banked

Overview:
- Multi-thread register file. Generalises the single-bank 2R1W register file to NTHREADS independent banks.
- Adds per-byte write enables, optional write-to-read bypass and an optional hardwired zero register.
- Adds a sequential per-thread bank-clear engine with a busy/done handshake.
- Sits between decode (read side) and writeback (write side) of the multithreaded pipeline.

Parameters:
DATAWIDTH, 64, register width in bits; must be a multiple of 8
RFDEPTH, 4, registers per thread bank; power of 2, >= 2
NTHREADS, 4, number of thread banks; >= 1, need not be a power of 2
BYPASS, 1, 1: a same-cycle write is visible on the read ports; 0: reads return stored contents only
ZERO_REG, 0, 1: address 0 of every bank reads as 0 and ignores writes

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
rtid  in  TW=max(1,$clog2(NTHREADS))  thread selected for both read ports
raddr1  in  AW=$clog2(RFDEPTH)  read address, port 1
raddr2  in  AW  read address, port 2
rdata1  out  DATAWIDTH  read data, port 1 (combinational)
rdata2  out  DATAWIDTH  read data, port 2 (combinational)
wen  in  1  write request
wtid  in  TW  write thread
waddr  in  AW  write address
wdata  in  DATAWIDTH  write data
wbe  in  DATAWIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
clr_req  in  1  request to clear bank clr_tid
clr_tid  in  TW  thread bank to clear
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All NTHREADS*RFDEPTH registers are set to 0.
  - The clear FSM returns to IDLE; clr_busy=0, clr_done=0.
  - Reset overrides wen and clr_req in the same cycle and aborts any clear in progress.
- Read (0-cycle latency):
  - rdata = bank[rtid][raddr].
  - rtid >= NTHREADS returns 0.
  - With ZERO_REG=1, raddr=0 returns 0.
- Write:
  - An effective write needs wen=1, wtid < NTHREADS, not (ZERO_REG and waddr=0), and not (clr_busy and wtid = latched clear tid).
  - At the edge, each byte i with wbe[i]=1 takes wdata byte i; the other bytes hold. wbe=0 is a no-op.
- Bypass (BYPASS=1 only):
  - Applies when an effective write has wtid=rtid and waddr=raddrN.
  - rdataN = stored value with the enabled bytes replaced by wdata bytes.
  - Both ports bypass independently.
  - Dropped writes never bypass.
- Clear FSM states IDLE, CLEAR, DONE:
  - IDLE: if clr_req=1 and clr_tid < NTHREADS, latch clr_tid, set idx=0, go to CLEAR. Otherwise stay; an out-of-range clr_tid is ignored.
  - CLEAR: clr_busy=1. Each cycle, bank[tid][idx] is set to 0 and idx increments. After idx=RFDEPTH-1 is written, go to DONE. Takes exactly RFDEPTH cycles.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then IDLE. A clr_req in DONE is ignored; a new request is accepted from IDLE the next cycle.
  - clr_req while busy is ignored; no queuing.
  - Writes to the thread being cleared are dropped for the whole of CLEAR. Writes to other threads proceed in parallel.
  - Reads of the thread being cleared return its current partially-cleared contents.
- Timing: clr_req sampled at edge 0 → clr_busy high after edge 0; last register zeroed at edge RFDEPTH; clr_done high for the cycle after edge RFDEPTH.

Decomposition:
- Package rf_mt_pkg holds:
  - TW/AW width helper functions.
  - Clear-FSM state enum (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2).
  - The byte-merge function (old, new, be) → merged, shared by the write path and the bypass path.
- One natural sub-module, rf_bank: a single-thread RFDEPTH x DATAWIDTH bank with byte-enabled write, a clear-write port and 2 async reads. It is instantiated NTHREADS times by generate.
- The clear FSM and bypass muxing stay in the top level.

Test Plan:
- Reset: write 0xDEAD to t1 r2, then rst_n=0 for 1 cycle → every t/r reads 0, clr_busy=0, clr_done=0.
- Byte enables: t0 r1 = 0x1111_1111_1111_1111; write wdata 0xFFFF_FFFF_FFFF_FFFF with wbe=8'h0F → reads 0x1111_1111_FFFF_FFFF.
- Bypass: BYPASS=1, t2 r3 = 0xAA, write 0xBB wbe=all, rtid=2, raddr1=raddr2=3 in the same cycle → both ports show 0xBB combinationally. With BYPASS=0 the ports show 0xAA, then 0xBB after the edge.
- Zero register: ZERO_REG=1, write 0x55 to t0 r0 → rdata=0. Writes to r1 still take effect.
- Clear: fill t3 with nonzero values, pulse clr_req tid=3 → clr_busy for RFDEPTH=4 cycles, then clr_done for 1 cycle, and t3 reads all 0. A concurrent write to t3 is dropped; a concurrent write to t1 r0=0x77 lands. A second clr_req during busy is ignored.
- Reset mid-clear: assert rst_n=0 at CLEAR idx=2 → FSM returns to IDLE, clr_busy=0, no clr_done pulse, all banks read 0.

Source files
------------

// File: rtl/rf_mt_pkg.sv
// -----------------------------------------------------------------------------
// rf_mt_pkg
// Shared definitions for the multi-thread banked register file:
//   - width helpers for thread-id and register-address fields
//   - clear-engine state encoding
//   - per-byte merge used by both the bank write path and the read bypass
// No ports (package).
// -----------------------------------------------------------------------------
package rf_mt_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    // Thread-id width; a single-thread build still carries a 1-bit tid.
    function automatic int tw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Register-address width within one bank.
    function automatic int aw_f(input int d);
        return $clog2(d);
    endfunction

    // One byte of a byte-enabled update: enabled bytes take the new value.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/rf_mt_banked_bank.sv
// -----------------------------------------------------------------------------
// rf_bank
// One thread's RFDEPTH x DATAWIDTH register bank.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (zeroes the bank)
//   i_wen/i_waddr/i_wdata/i_wbe   byte-enabled write port
//   i_clr/i_clr_addr      clear port: zeroes one register, wins over a write
//   i_raddr1/o_rdata1     asynchronous read port 1
//   i_raddr2/o_rdata2     asynchronous read port 2
// -----------------------------------------------------------------------------
module rf_bank
    import rf_mt_pkg::*;
#(
    parameter  int DATAWIDTH = 64,
    parameter  int RFDEPTH   = 4,
    localparam int AW        = aw_f(RFDEPTH),
    localparam int NB        = DATAWIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wen,
    input  logic [AW-1:0]        i_waddr,
    input  logic [DATAWIDTH-1:0] i_wdata,
    input  logic [NB-1:0]        i_wbe,
    input  logic                 i_clr,
    input  logic [AW-1:0]        i_clr_addr,
    input  logic [AW-1:0]        i_raddr1,
    input  logic [AW-1:0]        i_raddr2,
    output logic [DATAWIDTH-1:0] o_rdata1,
    output logic [DATAWIDTH-1:0] o_rdata2
);

    logic [DATAWIDTH-1:0] r_mem [RFDEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RFDEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_wen) begin
                for (int b = 0; b < NB; b++) begin
                    r_mem[i_waddr][8*b +: 8] <= merge_byte(r_mem[i_waddr][8*b +: 8],
                                                           i_wdata[8*b +: 8], i_wbe[b]);
                end
            end
            // Placed last so a clear always wins over a write to the same register.
            if (i_clr) begin
                r_mem[i_clr_addr] <= '0;
            end
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/rf_mt_banked.sv
// -----------------------------------------------------------------------------
// rf_mt_banked
// Multi-thread 2R1W register file: NTHREADS independent banks, byte-enabled
// writes, optional write-to-read bypass, optional hardwired zero register and a
// sequential per-thread bank-clear engine.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   rtid, raddr1/2, rdata1/2   combinational reads of thread rtid
//   wen, wtid, waddr, wdata, wbe   byte-enabled write
//   clr_req, clr_tid           request to clear one thread bank
//   clr_busy, clr_done         clear engine active / one-cycle completion pulse
// -----------------------------------------------------------------------------
module rf_mt_banked
    import rf_mt_pkg::*;
#(
    parameter  int DATAWIDTH = 64,
    parameter  int RFDEPTH   = 4,
    parameter  int NTHREADS  = 4,
    parameter  int BYPASS    = 1,
    parameter  int ZERO_REG  = 0,
    localparam int TW        = tw_f(NTHREADS),
    localparam int AW        = aw_f(RFDEPTH),
    localparam int NB        = DATAWIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TW-1:0]        rtid,
    input  logic [AW-1:0]        raddr1,
    input  logic [AW-1:0]        raddr2,
    output logic [DATAWIDTH-1:0] rdata1,
    output logic [DATAWIDTH-1:0] rdata2,
    input  logic                 wen,
    input  logic [TW-1:0]        wtid,
    input  logic [AW-1:0]        waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [NB-1:0]        wbe,
    input  logic                 clr_req,
    input  logic [TW-1:0]        clr_tid,
    output logic                 clr_busy,
    output logic                 clr_done
);

    // One extra bit so NTHREADS itself is representable for range checks.
    localparam logic [TW:0] NT_L = (TW+1)'(NTHREADS);

    clr_state_t    r_state;
    logic [TW-1:0] r_clr_tid;
    logic [AW-1:0] r_idx;
    logic          r_clr_busy;
    logic          r_clr_done;

    logic                 w_clr_tid_ok;
    logic                 w_wr_ok;
    logic                 w_byp1;
    logic                 w_byp2;
    logic [DATAWIDTH-1:0] w_bank_rd1 [NTHREADS];
    logic [DATAWIDTH-1:0] w_bank_rd2 [NTHREADS];
    logic [DATAWIDTH-1:0] w_sel_rd1;
    logic [DATAWIDTH-1:0] w_sel_rd2;

    assign w_clr_tid_ok = ({1'b0, clr_tid} < NT_L);

    // A write is effective only if it targets a real thread, is not aimed at
    // the hardwired zero register, and does not collide with a bank being cleared.
    assign w_wr_ok = wen
                   && ({1'b0, wtid} < NT_L)
                   && !((ZERO_REG != 0) && (waddr == '0))
                   && !(r_clr_busy && (wtid == r_clr_tid));

    generate
        for (genvar gi = 0; gi < NTHREADS; gi++) begin : g_bank
            rf_bank #(
                .DATAWIDTH (DATAWIDTH),
                .RFDEPTH   (RFDEPTH)
            ) u_bank (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_wen      (w_wr_ok && (wtid == TW'(gi))),
                .i_waddr    (waddr),
                .i_wdata    (wdata),
                .i_wbe      (wbe),
                .i_clr      ((r_state == CLR_CLEAR) && (r_clr_tid == TW'(gi))),
                .i_clr_addr (r_idx),
                .i_raddr1   (raddr1),
                .i_raddr2   (raddr2),
                .o_rdata1   (w_bank_rd1[gi]),
                .o_rdata2   (w_bank_rd2[gi])
            );
        end
    endgenerate

    // Thread select; an rtid with no matching bank leaves the zero default.
    always_comb begin
        w_sel_rd1 = '0;
        w_sel_rd2 = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (rtid == TW'(t)) begin
                w_sel_rd1 = w_bank_rd1[t];
                w_sel_rd2 = w_bank_rd2[t];
            end
        end
    end

    assign w_byp1 = (BYPASS != 0) && w_wr_ok && (wtid == rtid) && (waddr == raddr1);
    assign w_byp2 = (BYPASS != 0) && w_wr_ok && (wtid == rtid) && (waddr == raddr2);

    always_comb begin
        rdata1 = w_sel_rd1;
        rdata2 = w_sel_rd2;
        for (int b = 0; b < NB; b++) begin
            rdata1[8*b +: 8] = merge_byte(w_sel_rd1[8*b +: 8], wdata[8*b +: 8], wbe[b] && w_byp1);
            rdata2[8*b +: 8] = merge_byte(w_sel_rd2[8*b +: 8], wdata[8*b +: 8], wbe[b] && w_byp2);
        end
        if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
        end
        if ((ZERO_REG != 0) && (raddr2 == '0)) begin
            rdata2 = '0;
        end
    end

    // Clear engine: walks r_idx over the latched bank, one register per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= CLR_IDLE;
            r_clr_tid  <= '0;
            r_idx      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            case (r_state)
                CLR_IDLE: begin
                    r_clr_done <= 1'b0;
                    if (clr_req && w_clr_tid_ok) begin
                        r_clr_tid  <= clr_tid;
                        r_idx      <= '0;
                        r_clr_busy <= 1'b1;
                        r_state    <= CLR_CLEAR;
                    end
                end
                CLR_CLEAR: begin
                    if (r_idx == AW'(RFDEPTH - 1)) begin
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                        r_state    <= CLR_DONE;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                CLR_DONE: begin
                    r_clr_done <= 1'b0;
                    r_state    <= CLR_IDLE;
                end
                default: begin
                    r_clr_busy <= 1'b0;
                    r_clr_done <= 1'b0;
                    r_state    <= CLR_IDLE;
                end
            endcase
        end
    end

    assign clr_busy = r_clr_busy;
    assign clr_done = r_clr_done;

endmodule

// File: tb/tb_rf_mt_banked.sv
// -----------------------------------------------------------------------------
// tb_rf_mt_banked
// Two instances share every input: dut_a (BYPASS=1, ZERO_REG=0) and
// dut_b (BYPASS=0, ZERO_REG=1). A behavioural model of the register file
// predicts both every cycle; directed literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_rf_mt_banked;

    localparam int NT    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rtid, raddr1, raddr2;
    logic        wen;
    logic [1:0]  wtid, waddr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic        clr_req;
    logic [1:0]  clr_tid;

    logic [63:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
    logic        busy_a, done_a, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_mt_banked #(.DATAWIDTH(64), .RFDEPTH(DEPTH), .NTHREADS(NT), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rtid(rtid), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_a), .rdata2(rdata2_a), .wen(wen), .wtid(wtid), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .clr_req(clr_req), .clr_tid(clr_tid),
        .clr_busy(busy_a), .clr_done(done_a));

    rf_mt_banked #(.DATAWIDTH(64), .RFDEPTH(DEPTH), .NTHREADS(NT), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rtid(rtid), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_b), .rdata2(rdata2_b), .wen(wen), .wtid(wtid), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .clr_req(clr_req), .clr_tid(clr_tid),
        .clr_busy(busy_b), .clr_done(done_b));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Config 0 mirrors dut_a, config 1 mirrors dut_b.
    logic [63:0] m_mem [2][NT][DEPTH];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_tid  = 0;
    int          m_cnt  = 0;
    bit          model_valid = 1'b0;

    function automatic bit byp(input int c); return (c == 0); endfunction
    function automatic bit zr(input int c);  return (c == 1); endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] be);
        logic [63:0] mask = '0;
        for (int b = 0; b < 8; b++) if (be[b]) mask |= (64'hFF << (8*b));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic bit eff_write(input int c);
        return wen && (int'(wtid) < NT) && !(zr(c) && waddr == 2'd0)
               && !(m_busy && int'(wtid) == m_tid);
    endfunction

    function automatic logic [63:0] exp_rd(input int c, input logic [1:0] ra);
        logic [63:0] v;
        if (int'(rtid) >= NT) return 64'd0;
        if (zr(c) && ra == 2'd0) return 64'd0;
        v = m_mem[c][rtid][ra];
        if (byp(c) && eff_write(c) && wtid == rtid && waddr == ra) v = merge(v, wdata, wbe);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++)
                for (int t = 0; t < NT; t++)
                    for (int r = 0; r < DEPTH; r++) m_mem[c][t][r] = 64'd0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            model_valid = 1'b1;
        end else begin
            for (int c = 0; c < 2; c++)
                if (eff_write(c)) m_mem[c][wtid][waddr] = merge(m_mem[c][wtid][waddr], wdata, wbe);
            if (m_busy) begin
                for (int c = 0; c < 2; c++) m_mem[c][m_tid][m_cnt] = 64'd0;
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (clr_req && int'(clr_tid) < NT) begin
                m_busy = 1'b1;
                m_tid  = int'(clr_tid);
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("m_a_rdata1", rdata1_a, exp_rd(0, raddr1));
            chk("m_a_rdata2", rdata2_a, exp_rd(0, raddr2));
            chk("m_b_rdata1", rdata1_b, exp_rd(1, raddr1));
            chk("m_b_rdata2", rdata2_b, exp_rd(1, raddr2));
            chk("m_a_busy", 64'(busy_a), 64'(m_busy));
            chk("m_a_done", 64'(done_a), 64'(m_done));
            chk("m_b_busy", 64'(busy_b), 64'(m_busy));
            chk("m_b_done", 64'(done_b), 64'(m_done));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int t, input int r, input logic [63:0] d, input logic [7:0] be);
        wen = 1'b1; wtid = 2'(t); waddr = 2'(r); wdata = d; wbe = be;
        step();
        wen = 1'b0;
    endtask

    task automatic chk_rd(input string nm, input int t, input int r,
                          input logic [63:0] exp_a, input logic [63:0] exp_b);
        rtid = 2'(t); raddr1 = 2'(r); raddr2 = 2'(r);
        #1;
        chk({nm, "_a"}, rdata1_a, exp_a);
        chk({nm, "_b"}, rdata2_b, exp_b);
        step();
    endtask

    task automatic chk_busy(input string nm, input logic b, input logic d);
        chk({nm, "_busy"}, 64'(busy_a), 64'(b));
        chk({nm, "_done"}, 64'(done_a), 64'(d));
        chk({nm, "_busy_b"}, 64'(busy_b), 64'(b));
    endtask

    initial begin
        rst_n = 1'b0; rtid = '0; raddr1 = '0; raddr2 = '0;
        wen = 1'b0; wtid = '0; waddr = '0; wdata = '0; wbe = '0;
        clr_req = 1'b0; clr_tid = '0;
        step(); step();
        rst_n = 1'b1;
        #1 chk_busy("rst", 1'b0, 1'b0);

        // Reset clears written data
        wr(1, 2, 64'hDEAD, 8'hFF);
        chk_rd("pre_rst", 1, 2, 64'hDEAD, 64'hDEAD);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < DEPTH; r++) chk_rd("post_rst", t, r, 64'd0, 64'd0);
        chk_busy("post_rst", 1'b0, 1'b0);

        // Byte enables
        wr(0, 1, 64'h1111_1111_1111_1111, 8'hFF);
        wr(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        chk_rd("byte_en", 0, 1, 64'h1111_1111_FFFF_FFFF, 64'h1111_1111_FFFF_FFFF);

        // Bypass vs. no bypass
        wr(2, 3, 64'hAA, 8'hFF);
        wen = 1'b1; wtid = 2'd2; waddr = 2'd3; wdata = 64'hBB; wbe = 8'hFF;
        rtid = 2'd2; raddr1 = 2'd3; raddr2 = 2'd3;
        #1;
        chk("byp_a1", rdata1_a, 64'hBB);
        chk("byp_a2", rdata2_a, 64'hBB);
        chk("nobyp_b1", rdata1_b, 64'hAA);
        chk("nobyp_b2", rdata2_b, 64'hAA);
        step();
        wen = 1'b0;
        #1 chk("nobyp_b_after", rdata1_b, 64'hBB);
        // Partial-byte bypass on port 1 only
        wen = 1'b1; wtid = 2'd2; waddr = 2'd3; wdata = 64'h1122; wbe = 8'h02;
        raddr1 = 2'd3; raddr2 = 2'd2;
        #1;
        chk("byp_part_a1", rdata1_a, 64'h11BB);
        chk("byp_part_a2", rdata2_a, 64'h0);
        chk("byp_part_b1", rdata1_b, 64'hBB);
        step();
        wen = 1'b0;

        // Zero register
        wen = 1'b1; wtid = 2'd0; waddr = 2'd0; wdata = 64'h55; wbe = 8'hFF;
        rtid = 2'd0; raddr1 = 2'd0; raddr2 = 2'd0;
        #1;
        chk("zr_byp_a", rdata1_a, 64'h55);
        chk("zr_byp_b", rdata1_b, 64'h0);
        step();
        wen = 1'b0;
        #1;
        chk("zr_a", rdata1_a, 64'h55);
        chk("zr_b", rdata1_b, 64'h0);

        // Bank clear of t3
        for (int r = 0; r < DEPTH; r++) wr(3, r, 64'hC0DE_0000_0000_0001 + 64'(r), 8'hFF);
        clr_req = 1'b1; clr_tid = 2'd3;
        step();                                   // edge 0
        clr_req = 1'b0;
        wen = 1'b1; wtid = 2'd3; waddr = 2'd0; wdata = 64'h99; wbe = 8'hFF;
        #1 chk_busy("clr_e0", 1'b1, 1'b0);
        step();                                   // edge 1: t3 write dropped, r0 cleared
        wen = 1'b1; wtid = 2'd1; waddr = 2'd0; wdata = 64'h77; wbe = 8'hFF;
        clr_req = 1'b1; clr_tid = 2'd2;           // ignored while busy
        #1 chk_busy("clr_e1", 1'b1, 1'b0);
        step();                                   // edge 2
        wen = 1'b0; clr_req = 1'b0;
        rtid = 2'd3; raddr1 = 2'd0; raddr2 = 2'd3;
        #1;
        chk_busy("clr_e2", 1'b1, 1'b0);
        chk("clr_partial_r0", rdata1_a, 64'h0);
        chk("clr_partial_r3", rdata2_a, 64'hC0DE_0000_0000_0004);
        step();                                   // edge 3
        #1 chk_busy("clr_e3", 1'b1, 1'b0);
        step();                                   // edge 4: last register zeroed
        #1 chk_busy("clr_e4", 1'b0, 1'b1);
        clr_req = 1'b1; clr_tid = 2'd0;           // ignored in DONE
        step();
        clr_req = 1'b0;
        #1 chk_busy("clr_e5", 1'b0, 1'b0);
        step();
        #1 chk_busy("clr_e6", 1'b0, 1'b0);
        for (int r = 0; r < DEPTH; r++) chk_rd("clr_t3", 3, r, 64'd0, 64'd0);
        chk_rd("par_t1r0", 1, 0, 64'h77, 64'h0);
        chk_rd("t0_kept", 0, 1, 64'h1111_1111_FFFF_FFFF, 64'h1111_1111_FFFF_FFFF);
        chk_rd("t2_kept", 2, 3, 64'h11BB, 64'h11BB);

        // Reset in the middle of a clear
        clr_req = 1'b1; clr_tid = 2'd2;
        step();                                   // edge 0
        clr_req = 1'b0;
        step();                                   // edge 1
        step();                                   // edge 2: now clearing idx 2
        #1 chk_busy("mid_clr", 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1 chk_busy("mid_rst", 1'b0, 1'b0);
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < DEPTH; r++) chk_rd("mid_rst_rd", t, r, 64'd0, 64'd0);
        chk_busy("mid_rst_end", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
